microwave_timer_ctrl: RTL and testbench

Cook-time controller for the microwave. Holds a user-loaded MM:SS time and counts it down once per second while the door is closed and the oven is running. Drives the magnetron enable and a completion beep. Owns its own clock prescaler: the second tick is gated by the controller state, not free-running.

---
 rtl/microwave_pkg.sv | 25 ++
 rtl/microwave_timer_ctrl_if.sv | 27 ++
 rtl/sec_prescaler.sv | 29 ++
 rtl/microwave_timer_ctrl.sv | 121 ++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared types and limits for the microwave cook-time controller.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MIN_W = 7;
  localparam int SEC_W = 6;

  localparam logic [MIN_W-1:0] MAX_MIN = 7'd99;
  localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;

  function automatic logic [MIN_W-1:0] sat_min(input logic [MIN_W-1:0] m);
    return (m > MAX_MIN) ? MAX_MIN : m;
  endfunction

  function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] s);
    return (s > MAX_SEC) ? MAX_SEC : s;
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Front-panel buttons, time load bus and status outputs of the cook-time controller.
interface microwave_timer_ctrl_if;
  import microwave_pkg::*;

  logic             door_closed;
  logic             start_btn;
  logic             stop_btn;
  logic             load_en;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic [MIN_W-1:0] min_out;
  logic [SEC_W-1:0] sec_out;
  logic             magnetron_on;
  logic             beep;
  logic [2:0]       state_out;

  modport master (
    output door_closed, start_btn, stop_btn, load_en, load_min, load_sec,
    input  min_out, sec_out, magnetron_on, beep, state_out
  );

  modport slave (
    input  door_closed, start_btn, stop_btn, load_en, load_min, load_sec,
    output min_out, sec_out, magnetron_on, beep, state_out
  );

endinterface

// File: rtl/sec_prescaler.sv
// Modulus counter producing a one-cycle tick on its last count; clear beats enable.
module sec_prescaler #(
  parameter int MODULUS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int               CNT_W = $clog2(MODULUS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: MM:SS countdown, magnetron enable and completion beep.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int BEEP_SECS     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  microwave_timer_ctrl_if.slave bus
);

  localparam int              BC_W      = $clog2(BEEP_SECS + 1);
  localparam logic [BC_W-1:0] BEEP_LAST = BC_W'(BEEP_SECS - 1);

  state_t           r_state, w_state_nxt;
  logic [MIN_W-1:0] r_min, w_min_nxt;
  logic [SEC_W-1:0] r_sec, w_sec_nxt;
  logic [BC_W-1:0]  r_beep_cnt, w_beep_cnt_nxt;
  logic             r_mag, w_mag_nxt;
  logic             r_beep, w_beep_nxt;

  logic w_tick, w_en, w_clr, w_pause_req, w_time_zero, w_time_one;

  assign w_time_zero = (r_min == '0) && (r_sec == '0);
  assign w_time_one  = (r_min == '0) && (r_sec == SEC_W'(1));
  assign w_pause_req = bus.stop_btn || !bus.door_closed;

  // A pausing RUN cycle must not advance the prescaler, so its phase survives the pause.
  assign w_en  = ((r_state == RUN) && !w_pause_req) || (r_state == DONE);
  assign w_clr = (r_state == IDLE) || (w_state_nxt == IDLE);

  sec_prescaler #(.MODULUS(TICKS_PER_SEC)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (!bus.stop_btn && bus.door_closed && bus.start_btn && !w_time_zero)
               w_state_nxt = RUN;
      RUN:   if (w_pause_req)              w_state_nxt = PAUSE;
             else if (w_tick && w_time_one) w_state_nxt = DONE;
      PAUSE: if (bus.stop_btn)                           w_state_nxt = IDLE;
             else if (bus.door_closed && bus.start_btn)  w_state_nxt = RUN;
      DONE:  if (bus.stop_btn || bus.start_btn)          w_state_nxt = IDLE;
             else if (w_tick && (r_beep_cnt == BEEP_LAST)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_min_nxt      = r_min;
    w_sec_nxt      = r_sec;
    w_beep_cnt_nxt = '0;
    w_mag_nxt      = (r_state == RUN);
    w_beep_nxt     = (r_state == DONE);
    case (r_state)
      IDLE: begin
        if (bus.stop_btn) begin
          w_min_nxt = '0;
          w_sec_nxt = '0;
        end else if (bus.load_en) begin
          w_min_nxt = sat_min(bus.load_min);
          w_sec_nxt = sat_sec(bus.load_sec);
        end
      end
      RUN: begin
        // w_tick is already suppressed on pausing cycles.
        if (w_tick && !w_time_zero) begin
          if (r_sec != '0) begin
            w_sec_nxt = r_sec - 1'b1;
          end else begin
            w_sec_nxt = MAX_SEC;
            w_min_nxt = r_min - 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.stop_btn) begin
          w_min_nxt = '0;
          w_sec_nxt = '0;
        end
      end
      DONE: w_beep_cnt_nxt = w_tick ? r_beep_cnt + 1'b1 : r_beep_cnt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min      <= '0;
      r_sec      <= '0;
      r_beep_cnt <= '0;
      r_mag      <= 1'b0;
      r_beep     <= 1'b0;
    end else begin
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_beep_cnt <= w_beep_cnt_nxt;
      r_mag      <= w_mag_nxt;
      r_beep     <= w_beep_nxt;
    end
  end

  assign bus.min_out      = r_min;
  assign bus.sec_out      = r_sec;
  assign bus.magnetron_on = r_mag;
  assign bus.beep         = r_beep;
  assign bus.state_out    = {1'b0, r_state};

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed scoreboard bench for microwave_timer_ctrl with TICKS_PER_SEC=4, BEEP_SECS=2.
module tb_microwave_timer_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] mn;
    logic [5:0] sc;
    logic       mag;
    logic       bp;
  } obs_t;

  logic   clk;
  logic   rst_n;
  int     checks;
  int     errors;
  obs_t   exp_q[$];
  string  tag_q[$];

  microwave_timer_ctrl_if bus_if ();

  microwave_timer_ctrl #(
    .TICKS_PER_SEC (4),
    .BEEP_SECS     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_exp(input string tag, input logic [2:0] st, input logic [6:0] mn,
                          input logic [5:0] sc, input logic mag, input logic bp);
    obs_t e;
    e.st = st; e.mn = mn; e.sc = sc; e.mag = mag; e.bp = bp;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    obs_t  o;
    obs_t  e;
    string t;
    o.st  = bus_if.state_out;
    o.mn  = bus_if.min_out;
    o.sc  = bus_if.sec_out;
    o.mag = bus_if.magnetron_on;
    o.bp  = bus_if.beep;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed st=%0d %0d:%0d mag=%b beep=%b, expected st=%0d %0d:%0d mag=%b beep=%b",
             t, o.st, o.mn, o.sc, o.mag, o.bp, e.st, e.mn, e.sc, e.mag, e.bp);
    end
  endtask

  // Inputs set before the call are sampled on the next edge; pulses drop afterwards.
  task automatic step(input string tag, input logic [2:0] st, input logic [6:0] mn,
                      input logic [5:0] sc, input logic mag, input logic bp);
    push_exp(tag, st, mn, sc, mag, bp);
    @(posedge clk);
    #1;
    bus_if.start_btn = 1'b0;
    bus_if.stop_btn  = 1'b0;
    bus_if.load_en   = 1'b0;
    compare();
  endtask

  task automatic check_now(input string tag, input logic [2:0] st, input logic [6:0] mn,
                           input logic [5:0] sc, input logic mag, input logic bp);
    push_exp(tag, st, mn, sc, mag, bp);
    compare();
  endtask

  task automatic load(input logic [6:0] mn, input logic [5:0] sc);
    bus_if.load_en  = 1'b1;
    bus_if.load_min = mn;
    bus_if.load_sec = sc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.door_closed = 1'b1;
    bus_if.start_btn   = 1'b0;
    bus_if.stop_btn    = 1'b0;
    bus_if.load_en     = 1'b0;
    bus_if.load_min    = '0;
    bus_if.load_sec    = '0;
    #3;
    check_now("reset", S_IDLE, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full cook of 00:02 through DONE and beep back to IDLE.
    load(0, 2);                  step("t1_load",  S_IDLE, 0, 2, 0, 0);
    bus_if.start_btn = 1'b1;     step("t1_start", S_RUN,  0, 2, 0, 0);
    for (int i = 0; i < 3; i++)  step("t1_run2",  S_RUN,  0, 2, 1, 0);
                                 step("t1_tick1", S_RUN,  0, 1, 1, 0);
    for (int i = 0; i < 3; i++)  step("t1_run1",  S_RUN,  0, 1, 1, 0);
                                 step("t1_done",  S_DONE, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++)  step("t1_beep",  S_DONE, 0, 0, 0, 1);
                                 step("t1_idle",  S_IDLE, 0, 0, 0, 1);
                                 step("t1_quiet", S_IDLE, 0, 0, 0, 0);

    // Minute borrow, then saturation of oversize loads.
    load(1, 0);                  step("t2_load",   S_IDLE,  1, 0, 0, 0);
    bus_if.start_btn = 1'b1;     step("t2_start",  S_RUN,   1, 0, 0, 0);
    for (int i = 0; i < 3; i++)  step("t2_run",    S_RUN,   1, 0, 1, 0);
                                 step("t2_borrow", S_RUN,   0, 59, 1, 0);
    bus_if.stop_btn = 1'b1;      step("t2_pause",  S_PAUSE, 0, 59, 1, 0);
    bus_if.stop_btn = 1'b1;      step("t2_cancel", S_IDLE,  0, 0, 0, 0);
    load(120, 63);               step("t2_sat",    S_IDLE,  99, 59, 0, 0);
    load(99, 60);                step("t2_sat_b",  S_IDLE,  99, 59, 0, 0);
    bus_if.stop_btn = 1'b1;      step("t2_clear",  S_IDLE,  0, 0, 0, 0);

    // Door opens on the tick cycle; resume keeps prescaler phase.
    load(0, 5);                  step("t3_load",   S_IDLE,  0, 5, 0, 0);
    bus_if.start_btn = 1'b1;     step("t3_start",  S_RUN,   0, 5, 0, 0);
    for (int i = 0; i < 3; i++)  step("t3_run",    S_RUN,   0, 5, 1, 0);
    bus_if.door_closed = 1'b0;   step("t3_door",   S_PAUSE, 0, 5, 1, 0);
                                 step("t3_magoff", S_PAUSE, 0, 5, 0, 0);
    bus_if.start_btn = 1'b1;     step("t3_opnstr", S_PAUSE, 0, 5, 0, 0);
    bus_if.door_closed = 1'b1;
    bus_if.start_btn = 1'b1;     step("t3_resume", S_RUN,   0, 5, 0, 0);
                                 step("t3_phase",  S_RUN,   0, 4, 1, 0);
    bus_if.start_btn = 1'b1;
    bus_if.stop_btn  = 1'b1;     step("t3_both",   S_PAUSE, 0, 4, 1, 0);
    bus_if.stop_btn = 1'b1;      step("t3_cancel", S_IDLE,  0, 0, 0, 0);
    bus_if.start_btn = 1'b1;     step("t3_zero",   S_IDLE,  0, 0, 0, 0);
    load(0, 3);                  step("t3_load3",  S_IDLE,  0, 3, 0, 0);
    bus_if.door_closed = 1'b0;
    bus_if.start_btn = 1'b1;     step("t3_opnidl", S_IDLE,  0, 3, 0, 0);
    bus_if.door_closed = 1'b1;

    // Start acknowledges DONE immediately.
    load(0, 1);                  step("t4_load",   S_IDLE, 0, 1, 0, 0);
    bus_if.start_btn = 1'b1;     step("t4_start",  S_RUN,  0, 1, 0, 0);
    for (int i = 0; i < 3; i++)  step("t4_run",    S_RUN,  0, 1, 1, 0);
                                 step("t4_done",   S_DONE, 0, 0, 1, 0);
                                 step("t4_beep",   S_DONE, 0, 0, 0, 1);
    bus_if.start_btn = 1'b1;     step("t4_ack",    S_IDLE, 0, 0, 0, 1);
                                 step("t4_quiet",  S_IDLE, 0, 0, 0, 0);

    // Load ignored while running, then asynchronous reset mid-cook.
    load(0, 3);                  step("t5_load",   S_IDLE, 0, 3, 0, 0);
    bus_if.start_btn = 1'b1;     step("t5_start",  S_RUN,  0, 3, 0, 0);
    load(5, 5);                  step("t5_ldrun",  S_RUN,  0, 3, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("t5_rst_async", S_IDLE, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_now("t5_rst_hold", S_IDLE, 0, 0, 0, 0);
    rst_n = 1'b1;
                                 step("t5_post",   S_IDLE, 0, 0, 0, 0);
                                 step("t5_post2",  S_IDLE, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
